// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, widths, MEM/WB bundle.
// Imported by the memory stage and its data RAM.
package mips_pkg;

  localparam int ADDR_BITS_DEF = 12;
  localparam int TNEW_W = 2;

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] SH  = 6'b101001;
  localparam logic [5:0] SB  = 6'b101000;

  typedef enum logic [1:0] {
    SZ_NONE,
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  typedef struct packed {
    logic [5:0]        op;
    logic [5:0]        func;
    logic [31:0]       pc;
    logic [4:0]        wa;
    logic              rw;
    logic [TNEW_W-1:0] tnew;
    logic [31:0]       alu;
    logic [31:0]       dm;
    logic              err;
  } mem_wb_t;

  function automatic logic [TNEW_W-1:0] tnew_dec(
    input logic [TNEW_W-1:0] t
  );
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

endpackage

// File: rtl/mem_stage_dm_ram.sv
// Data memory: 2^AW x 32 words, byte-enable synchronous write,
// combinational read. Ports: clk, we, be, addr, wdata, rdata.
module dm_ram
  import mips_pkg::*;
#(
  parameter int AW = ADDR_BITS_DEF
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: lane decode, alignment check, load extension,
// data RAM and MEM/WB register. Inputs *_M from EX/MEM, outputs *_W.
module mem_stage
  import mips_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en34,
  input  logic              flush34,
  input  logic [5:0]        op_M,
  input  logic [5:0]        func_M,
  input  logic [31:0]       PC_M,
  input  logic [4:0]        regWA_M,
  input  logic              RegWrite_M,
  input  logic [TNEW_W-1:0] Tnew_M,
  input  logic [31:0]       ALUOut_M,
  input  logic [31:0]       storeData_M,
  output logic [5:0]        op_W,
  output logic [5:0]        func_W,
  output logic [31:0]       PC_W,
  output logic [4:0]        regWA_W,
  output logic              RegWrite_W,
  output logic [TNEW_W-1:0] Tnew_W,
  output logic [31:0]       ALUOut_W,
  output logic [31:0]       DMOut_W,
  output logic              addrErr_W
);

  logic        is_ld;
  logic        is_st;
  logic        sgn;
  size_e       sz;
  logic [1:0]  lane;
  logic        err;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] sh;
  logic [31:0] ld;
  logic        we;
  mem_wb_t     nxt;
  mem_wb_t     w;

  assign lane = ALUOut_M[1:0];

  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    sgn   = 1'b0;
    sz    = SZ_NONE;
    unique case (1'b1)
      op_M == LW:  begin is_ld = 1'b1; sz = SZ_WORD; end
      op_M == LH:  begin is_ld = 1'b1; sz = SZ_HALF; sgn = 1'b1; end
      op_M == LHU: begin is_ld = 1'b1; sz = SZ_HALF; end
      op_M == LB:  begin is_ld = 1'b1; sz = SZ_BYTE; sgn = 1'b1; end
      op_M == LBU: begin is_ld = 1'b1; sz = SZ_BYTE; end
      op_M == SW:  begin is_st = 1'b1; sz = SZ_WORD; end
      op_M == SH:  begin is_st = 1'b1; sz = SZ_HALF; end
      op_M == SB:  begin is_st = 1'b1; sz = SZ_BYTE; end
      default: ;
    endcase
  end

  assign err = (sz == SZ_WORD && lane != 2'b00)
             || (sz == SZ_HALF && lane[0]);

  always_comb begin
    be    = 4'b0000;
    wdata = storeData_M;
    unique case (sz)
      SZ_WORD: be = 4'b1111;
      SZ_HALF: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{storeData_M[15:0]}};
      end
      SZ_BYTE: begin
        be    = 4'b0001 << lane;
        wdata = {4{storeData_M[7:0]}};
      end
      default: ;
    endcase
  end

  assign we = is_st & ~err & en34 & ~flush34;

  dm_ram #(.AW(ADDR_BITS)) u_ram (
    .clk   (clk),
    .we    (we),
    .be    (be),
    .addr  (ALUOut_M[ADDR_BITS+1:2]),
    .wdata (wdata),
    .rdata (rdata)
  );

  // Bring the addressed lane down to bit 0 before extending.
  assign sh = rdata >> {lane, 3'b000};

  always_comb begin
    ld = '0;
    if (is_ld && !err) begin
      unique case (sz)
        SZ_WORD: ld = rdata;
        SZ_HALF: ld = {{16{sgn & sh[15]}}, sh[15:0]};
        SZ_BYTE: ld = {{24{sgn & sh[7]}}, sh[7:0]};
        default: ld = '0;
      endcase
    end
  end

  always_comb begin
    nxt      = '0;
    nxt.op   = op_M;
    nxt.func = func_M;
    nxt.pc   = PC_M;
    nxt.wa   = regWA_M;
    nxt.rw   = RegWrite_M & ~err;
    nxt.tnew = tnew_dec(Tnew_M);
    nxt.alu  = ALUOut_M;
    nxt.dm   = ld;
    nxt.err  = err;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w <= '0;
    end else if (en34) begin
      if (flush34) w <= '0;
      else         w <= nxt;
    end
  end

  assign op_W       = w.op;
  assign func_W     = w.func;
  assign PC_W       = w.pc;
  assign regWA_W    = w.wa;
  assign RegWrite_W = w.rw;
  assign Tnew_W     = w.tnew;
  assign ALUOut_W   = w.alu;
  assign DMOut_W    = w.dm;
  assign addrErr_W  = w.err;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, random run against a
// byte-level memory model, and asynchronous reset checks.
module tb_mem_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        en34 = 1'b1;
  logic        flush34 = 1'b0;
  logic [5:0]  op_M = '0;
  logic [5:0]  func_M = '0;
  logic [31:0] PC_M = '0;
  logic [4:0]  regWA_M = '0;
  logic        RegWrite_M = 1'b0;
  logic [1:0]  Tnew_M = '0;
  logic [31:0] ALUOut_M = '0;
  logic [31:0] storeData_M = '0;
  logic [5:0]  op_W, func_W;
  logic [31:0] PC_W, ALUOut_W, DMOut_W;
  logic [4:0]  regWA_W;
  logic        RegWrite_W, addrErr_W;
  logic [1:0]  Tnew_W;

  int n_chk = 0;
  int n_fail = 0;

  mem_stage dut (
    .clk(clk), .reset_n(reset_n), .en34(en34), .flush34(flush34),
    .op_M(op_M), .func_M(func_M), .PC_M(PC_M), .regWA_M(regWA_M),
    .RegWrite_M(RegWrite_M), .Tnew_M(Tnew_M), .ALUOut_M(ALUOut_M),
    .storeData_M(storeData_M), .op_W(op_W), .func_W(func_W),
    .PC_W(PC_W), .regWA_W(regWA_W), .RegWrite_W(RegWrite_W),
    .Tnew_W(Tnew_W), .ALUOut_W(ALUOut_W), .DMOut_W(DMOut_W),
    .addrErr_W(addrErr_W)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  tnew;
    logic        rw;
    logic        en;
    logic        fl;
    logic        chk_dm;
    logic [31:0] x_dm;
    logic        x_err;
    logic        x_rw;
    logic [1:0]  x_tnew;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    logic [5:0] op, logic [31:0] a, logic [31:0] d, logic [1:0] t,
    logic rw, logic en, logic fl, logic cd, logic [31:0] xd,
    logic xe, logic xr, logic [1:0] xt);
    vec_t v;
    v.op = op; v.addr = a; v.data = d; v.tnew = t; v.rw = rw;
    v.en = en; v.fl = fl; v.chk_dm = cd; v.x_dm = xd;
    v.x_err = xe; v.x_rw = xr; v.x_tnew = xt;
    return v;
  endfunction

  // Reference model: byte-addressed memory and expected W bundle.
  logic [7:0]  mb [int];
  logic [5:0]  m_op, m_func;
  logic [31:0] m_pc, m_alu, m_dm;
  logic [4:0]  m_wa;
  logic        m_rw, m_err;
  logic [1:0]  m_tnew;

  function automatic int nbytes(logic [5:0] op);
    if (op == LW || op == SW) return 4;
    if (op == LH || op == LHU || op == SH) return 2;
    if (op == LB || op == LBU || op == SB) return 1;
    return 0;
  endfunction

  task automatic model_step();
    int n;
    int base;
    logic ld, st, bad;
    logic [31:0] v;
    n = nbytes(op_M);
    ld = (op_M inside {LW, LH, LHU, LB, LBU});
    st = (op_M inside {SW, SH, SB});
    base = int'(ALUOut_M[13:0]);
    bad = (n > 1) && (base % n != 0);
    if (!en34) return;
    if (flush34) begin
      m_op = 0; m_func = 0; m_pc = 0; m_wa = 0; m_rw = 0;
      m_tnew = 0; m_alu = 0; m_dm = 0; m_err = 0;
      return;
    end
    v = 0;
    if (ld && !bad) begin
      for (int i = 0; i < n; i++)
        v |= 32'(mb.exists(base + i) ? mb[base + i] : 8'h00) << (8 * i);
      if (op_M == LH && v[15]) v |= 32'hFFFF0000;
      if (op_M == LB && v[7]) v |= 32'hFFFFFF00;
    end
    if (st && !bad) begin
      for (int i = 0; i < n; i++)
        mb[base + i] = storeData_M[8*i +: 8];
    end
    m_op = op_M; m_func = func_M; m_pc = PC_M; m_wa = regWA_M;
    m_rw = RegWrite_M && !bad;
    m_tnew = (Tnew_M > 0) ? Tnew_M - 2'd1 : 2'd0;
    m_alu = ALUOut_M; m_dm = v; m_err = bad;
  endtask

  task automatic model_chk();
    chk("op_W", 64'(op_W), 64'(m_op));
    chk("func_W", 64'(func_W), 64'(m_func));
    chk("PC_W", 64'(PC_W), 64'(m_pc));
    chk("regWA_W", 64'(regWA_W), 64'(m_wa));
    chk("RegWrite_W", 64'(RegWrite_W), 64'(m_rw));
    chk("Tnew_W", 64'(Tnew_W), 64'(m_tnew));
    chk("ALUOut_W", 64'(ALUOut_W), 64'(m_alu));
    chk("addrErr_W", 64'(addrErr_W), 64'(m_err));
    if (!m_err) chk("DMOut_W", 64'(DMOut_W), 64'(m_dm));
  endtask

  task automatic drive(logic [5:0] op, logic [31:0] a, logic [31:0] d,
                       logic [1:0] t, logic rw, logic en, logic fl);
    op_M = op; ALUOut_M = a; storeData_M = d; Tnew_M = t;
    RegWrite_M = rw; en34 = en; flush34 = fl;
    func_M = 6'($urandom); PC_M = $urandom; regWA_M = 5'($urandom);
  endtask

  logic [5:0] ops [9];
  logic [96:0] wall;

  initial begin
    ops = '{LW, LH, LHU, LB, LBU, SW, SH, SB, 6'h00};

    #1 reset_n = 1'b0;
    #2;
    wall = {op_W, func_W, PC_W, regWA_W, RegWrite_W, Tnew_W,
            DMOut_W[13:0], addrErr_W};
    chk("reset_all_w", 64'(wall), 64'd0);
    chk("reset_alu", 64'(ALUOut_W), 64'd0);
    chk("reset_dm", 64'(DMOut_W), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    tv.push_back(mk(SW, 32'h20, 32'h11112222, 1, 0, 1, 0, 1, 0, 0, 0, 0));
    tv.push_back(mk(SW, 32'h10, 32'h12345678, 1, 0, 1, 0, 1, 0, 0, 0, 0));
    tv.push_back(mk(LW, 32'h10, 32'h0, 2, 1, 1, 0, 1, 32'h12345678, 0, 1, 1));
    tv.push_back(mk(SB, 32'h13, 32'hAB, 1, 0, 1, 0, 1, 0, 0, 0, 0));
    tv.push_back(mk(LW, 32'h10, 32'h0, 0, 1, 1, 0, 1, 32'hAB345678, 0, 1, 0));
    tv.push_back(mk(LB, 32'h13, 32'h0, 1, 1, 1, 0, 1, 32'hFFFFFFAB, 0, 1, 0));
    tv.push_back(mk(LBU, 32'h13, 32'h0, 1, 1, 1, 0, 1, 32'h000000AB, 0, 1, 0));
    tv.push_back(mk(SH, 32'h12, 32'h8001, 1, 0, 1, 0, 1, 0, 0, 0, 0));
    tv.push_back(mk(LH, 32'h12, 32'h0, 2, 1, 1, 0, 1, 32'hFFFF8001, 0, 1, 1));
    tv.push_back(mk(LHU, 32'h12, 32'h0, 3, 1, 1, 0, 1, 32'h00008001, 0, 1, 2));
    tv.push_back(mk(LW, 32'h11, 32'h0, 1, 1, 1, 0, 0, 0, 1, 0, 0));
    tv.push_back(mk(SH, 32'h11, 32'hFFFF, 1, 0, 1, 0, 0, 0, 1, 0, 0));
    tv.push_back(mk(LW, 32'h10, 32'h0, 2, 1, 1, 0, 1, 32'h80015678, 0, 1, 1));
    tv.push_back(mk(SW, 32'h20, 32'hDEADBEEF, 1, 0, 0, 0, 1, 32'h80015678, 0, 1, 1));
    tv.push_back(mk(LW, 32'h20, 32'h0, 1, 1, 1, 0, 1, 32'h11112222, 0, 1, 0));
    tv.push_back(mk(LW, 32'h10, 32'h0, 2, 1, 1, 1, 1, 32'h0, 0, 0, 0));

    @(posedge clk); #1;
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].op, tv[i].addr, tv[i].data, tv[i].tnew, tv[i].rw,
            tv[i].en, tv[i].fl);
      step();
      if (tv[i].chk_dm)
        chk($sformatf("vec%0d_dm", i), 64'(DMOut_W), 64'(tv[i].x_dm));
      chk($sformatf("vec%0d_err", i), 64'(addrErr_W), 64'(tv[i].x_err));
      chk($sformatf("vec%0d_rw", i), 64'(RegWrite_W), 64'(tv[i].x_rw));
      chk($sformatf("vec%0d_tnew", i), 64'(Tnew_W), 64'(tv[i].x_tnew));
    end
    chk("flush_op", 64'(op_W), 64'd0);
    chk("flush_pc", 64'(PC_W), 64'd0);

    m_op = 0; m_func = 0; m_pc = 0; m_wa = 0; m_rw = 0;
    m_tnew = 0; m_alu = 0; m_dm = 0; m_err = 0;

    for (int i = 0; i < 16; i++) begin
      drive(SW, 32'h100 + 32'(4 * i), $urandom, 2'($urandom), 1'b0,
            1'b1, 1'b0);
      model_step();
      step();
      model_chk();
    end

    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      a = 32'h100 + 32'($urandom_range(0, 63));
      a[31:14] = 18'($urandom);
      drive(ops[$urandom_range(0, 8)], a, $urandom, 2'($urandom),
            1'($urandom), $urandom_range(0, 9) != 0,
            $urandom_range(0, 9) == 0);
      model_step();
      step();
      model_chk();
    end

    drive(LW, 32'h100, 0, 2'd3, 1'b1, 1'b1, 1'b0);
    step();
    #2 reset_n = 1'b0;
    #1;
    wall = {op_W, func_W, PC_W, regWA_W, RegWrite_W, Tnew_W,
            DMOut_W[13:0], addrErr_W};
    chk("midcycle_reset", 64'(wall), 64'd0);
    chk("midcycle_reset_dm", 64'(DMOut_W), 64'd0);
    chk("midcycle_reset_alu", 64'(ALUOut_W), 64'd0);
    #10 reset_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
